vga_sync_gen: RTL and testbench

- Raster timing generator for the pong display path.
- Divides the board clock down to the pixel rate and maintains horizontal and vertical counters.
- Drives the 10-bit x/y scan coordinates consumed by every glyph and sprite renderer (start_x/start_y compare blocks), plus hsync, vsync, video_on and a per-frame game-update pulse.
- Sits directly upstream of all character/paddle/ball display blocks and the RGB mux.

---
 rtl/vga_sync_gen_pkg.sv | 33 +++
 rtl/vga_sync_gen_pixel_tick_gen.sv | 33 +++
 rtl/vga_sync_gen.sv | 93 +++++++++
 tb/tb_vga_sync_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants for the pong display path.
// Every glyph, sprite and paddle renderer uses the same coordinate width and type.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Default 640x480@60 timing, using a 25 MHz pixel clock derived from a 100 MHz board clock.
    localparam int CLK_DIV_DEF   = 4;
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam bit SYNC_POL_DEF  = 1'b0;

    localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // Half-open window test: the result is true when lo <= v < hi.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Board-clock to pixel-rate divider.
// The wrap_o output is combinational and lets the raster counters step on the same edge that p_tick_o rises.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick_o,
    output logic wrap_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q;

    assign wrap_o   = (div_q == DIV_LAST);
    assign div_d    = wrap_o ? '0 : div_q + DIV_W'(1);
    assign p_tick_o = p_tick_q;

    // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            p_tick_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            p_tick_q <= wrap_o;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate x/y scan counters with registered syncs, video_on and frame_tick.
// Both totals must stay <= 1024 to fit the 10-bit coordinate bus.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = SYNC_POL_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic   pix_wrap;
    coord_t x_q, x_d, y_q, y_d;
    logic   hsync_q, vsync_q, video_on_q, frame_tick_q;
    logic   end_of_frame;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_tick_o (p_tick),
        .wrap_o   (pix_wrap)
    );

    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        end_of_frame = pix_wrap && (x_q == H_LAST) && (y_q == V_LAST);
        if (pix_wrap) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // The decodes use the next counter values, so the syncs and video_on change on the same edge as x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            video_on_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= in_window(x_d, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_q      <= in_window(y_d, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            video_on_q   <= (x_d < H_VIS) && (y_d < V_VIS);
            frame_tick_q <= end_of_frame;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default 640x480 build (A), a CLK_DIV=1/SYNC_POL=1 build (B) and a tiny-raster build (S).
// The bench derives the expected B and S outputs from the number of edges elapsed since reset was released.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_tick_a;
    logic [9:0] x_a, y_a;
    logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_tick_b;
    logic [9:0] x_b, y_b;
    logic       p_tick_s, hsync_s, vsync_s, video_on_s, frame_tick_s;
    logic [9:0] x_s, y_s;

    vga_sync_gen u_a (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick_a), .x(x_a), .y(y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .frame_tick(frame_tick_a)
    );

    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick_b), .x(x_b), .y(y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .frame_tick(frame_tick_b)
    );

    // Tiny raster: H_TOTAL=16 (hsync at 10..12), V_TOTAL=8 (vsync at 5..6), two clocks per pixel.
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
    ) u_s (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick_s), .x(x_s), .y(y_s),
        .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s), .frame_tick(frame_tick_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int err_b   = 0;
    int err_s   = 0;
    int ft_s    = 0;
    int lines_s = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample at the falling edge and score builds B and S against the edge-count model.
    task automatic step();
        int xb, yb, pc, xs, ys;
        @(negedge clk);
        k++;
        xb = k % 800;
        yb = (k / 800) % 525;
        if (x_b !== 10'(xb) || y_b !== 10'(yb) || p_tick_b !== 1'b1 ||
            hsync_b !== 1'(xb >= 656 && xb < 752) || vsync_b !== 1'(yb >= 490 && yb < 492) ||
            video_on_b !== 1'(xb < 640 && yb < 480) || frame_tick_b !== 1'(xb == 0 && yb == 0))
            err_b++;
        pc = k / 2;
        xs = pc % 16;
        ys = (pc / 16) % 8;
        if (x_s !== 10'(xs) || y_s !== 10'(ys) || p_tick_s !== 1'(k % 2 == 0) ||
            hsync_s !== 1'(!(xs >= 10 && xs < 13)) || vsync_s !== 1'(!(ys >= 5 && ys < 7)) ||
            video_on_s !== 1'(xs < 8 && ys < 4) || frame_tick_s !== 1'(k % 2 == 0 && pc % 128 == 0))
            err_s++;
        if (frame_tick_s === 1'b1) ft_s++;
        if (p_tick_s === 1'b1 && x_s === 10'd0) lines_s++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        repeat (10) @(negedge clk);
        check("rst_x",        x_a, 0);
        check("rst_y",        y_a, 0);
        check("rst_hsync",    hsync_a, 1);
        check("rst_vsync",    vsync_a, 1);
        check("rst_video_on", video_on_a, 0);
        check("rst_p_tick",   p_tick_a, 0);
        check("rst_frame",    frame_tick_a, 0);
        check("rst_b_hsync",  hsync_b, 0);
        check("rst_b_p_tick", p_tick_b, 0);

        rst_n = 1'b1;
        step();
        check("k1_video_on", video_on_a, 1);
        check("k1_x",        x_a, 0);
        run_to(3);
        check("k3_p_tick", p_tick_a, 0);
        check("k3_x",      x_a, 0);
        step();
        check("k4_p_tick", p_tick_a, 1);
        check("k4_x",      x_a, 1);
        step();
        check("k5_p_tick", p_tick_a, 0);
        check("k5_x",      x_a, 1);

        run_to(255);
        check("s_last_x",     x_s, 15);
        check("s_last_y",     y_s, 7);
        check("s_last_frame", frame_tick_s, 0);
        step();
        check("s_wrap_x",     x_s, 0);
        check("s_wrap_y",     y_s, 0);
        check("s_wrap_frame", frame_tick_s, 1);
        step();
        check("s_frame_pulse_end", frame_tick_s, 0);
        run_to(520);
        check("s_frames_2", ft_s, 2);
        check("s_lines_16", lines_s, 16);

        run_to(655);
        check("b_x655_hsync", hsync_b, 0);
        step();
        check("b_x656_hsync", hsync_b, 1);
        run_to(799);
        check("b_x799", x_b, 799);
        step();
        check("b_wrap_x", x_b, 0);
        check("b_wrap_y", y_b, 1);

        run_to(2559);
        check("a_x639",          x_a, 639);
        check("a_x639_video_on", video_on_a, 1);
        step();
        check("a_x640",          x_a, 640);
        check("a_x640_video_on", video_on_a, 0);
        run_to(2623);
        check("a_x655",       x_a, 655);
        check("a_x655_hsync", hsync_a, 1);
        step();
        check("a_x656",       x_a, 656);
        check("a_x656_hsync", hsync_a, 0);
        run_to(3007);
        check("a_x751_hsync", hsync_a, 0);
        step();
        check("a_x752",       x_a, 752);
        check("a_x752_hsync", hsync_a, 1);
        run_to(3199);
        check("a_x799", x_a, 799);
        check("a_y0",   y_a, 0);
        step();
        check("a_wrap_x",      x_a, 0);
        check("a_wrap_y",      y_a, 1);
        check("a_wrap_p_tick", p_tick_a, 1);
        check("b_model_first", err_b, 0);
        check("s_model_first", err_s, 0);

        run_to(3300);
        check("a_mid_x", x_a, 25);
        check("a_mid_y", y_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_x",        x_a, 0);
        check("async_y",        y_a, 0);
        check("async_video_on", video_on_a, 0);
        check("async_s_x",      x_s, 0);
        check("async_s_y",      y_s, 0);
        check("async_s_hsync",  hsync_s, 1);
        check("async_b_hsync",  hsync_b, 0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        k       = 0;
        ft_s    = 0;
        lines_s = 0;
        run_to(4);
        check("resume_x",      x_a, 1);
        check("resume_y",      y_a, 0);
        check("resume_p_tick", p_tick_a, 1);
        check("resume_s_x",    x_s, 2);
        run_to(300);
        check("b_model_final", err_b, 0);
        check("s_model_final", err_s, 0);
        check("s_frames_1",    ft_s, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
